// File: rtl/lockstep_recovery_pkg.sv
// Shared types and sizes for the lockstep checkpoint/rollback sequencer.
package lockstep_recovery_pkg;

   localparam int unsigned NUM_REGS   = 31;
   localparam int unsigned RF_AW      = 5;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned RETRY_W    = 8;
   localparam int unsigned ROLLBACK_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_DRAIN_C = 3'd2,
      ST_SAVE    = 3'd3,
      ST_DRAIN_R = 3'd4,
      ST_RESTORE = 3'd5,
      ST_SETPC   = 3'd6,
      ST_FATAL   = 3'd7
   } state_e;

endpackage

// File: rtl/lockstep_recovery_ctrl_ckpt_regfile.sv
// Double-buffered shadow register file: writes land in the inactive bank,
// reads come from the active bank, a flip strobe swaps them.
module ckpt_regfile
   import lockstep_recovery_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flip_i,
   input  logic             we_i,
   input  logic [RF_AW-1:0] waddr_i,
   input  logic [XLEN-1:0]  wdata_i,
   input  logic [RF_AW-1:0] raddr_i,
   output logic [XLEN-1:0]  rdata_c
);

   logic [XLEN-1:0] bank_q [2][NUM_REGS];
   logic [XLEN-1:0] bank_d [2][NUM_REGS];
   logic            act_q;
   logic            act_d;

   // Register index 1..31 maps to storage slot 0..30; x0 has no storage.
   always_comb begin
      bank_d = bank_q;
      act_d  = act_q;
      if (we_i && (waddr_i != '0)) begin
         bank_d[~act_q][waddr_i - RF_AW'(1)] = wdata_i;
      end
      if (flip_i) begin
         act_d = ~act_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
               bank_q[b][i] <= '0;
            end
         end
         act_q <= 1'b0;
      end else begin
         bank_q <= bank_d;
         act_q  <= act_d;
      end
   end

   always_comb begin
      rdata_c = '0;
      if (raddr_i != '0) begin
         rdata_c = bank_q[act_q][raddr_i - RF_AW'(1)];
      end
   end

endmodule

// File: rtl/lockstep_recovery_ctrl.sv
// Checkpoint/rollback sequencer for a dual-core lockstep pair: periodic
// register-file snapshots and error-triggered restore with PC redirect.
module lockstep_recovery_ctrl
   import lockstep_recovery_pkg::*;
#(
   parameter int unsigned CKPT_INTERVAL = 64,
   parameter int unsigned DRAIN_TIMEOUT = 16,
   parameter int unsigned MAX_RETRY     = 3,
   parameter logic [31:0] BOOT_ADDR     = 32'h0000_0080
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  error_i,
   input  logic                  retire_i,
   input  logic [XLEN-1:0]       pc_i,
   input  logic                  core_idle_i,
   input  logic [XLEN-1:0]       rf_rdata_i,
   output logic                  fetch_enable_o,
   output logic [RF_AW-1:0]      rf_addr_o,
   output logic [XLEN-1:0]       rf_wdata_o,
   output logic                  rf_we_o,
   output logic                  pc_set_o,
   output logic [XLEN-1:0]       pc_set_val_o,
   output logic [ROLLBACK_W-1:0] rollback_count_o,
   output logic                  fatal_o,
   output logic [2:0]            state_o
);

   localparam int unsigned RET_W = $clog2(CKPT_INTERVAL + 1);
   localparam int unsigned DRN_W = $clog2(DRAIN_TIMEOUT + 1);

   state_e                state_q, state_d;
   logic [RET_W-1:0]      ret_q, ret_d;
   logic [DRN_W-1:0]      drn_q, drn_d;
   logic [RETRY_W-1:0]    retry_q, retry_d;
   logic [ROLLBACK_W-1:0] rb_q, rb_d;
   logic [XLEN-1:0]       pend_pc_q, pend_pc_d;
   logic [XLEN-1:0]       ckpt_pc_q, ckpt_pc_d;
   logic [RF_AW-1:0]      rf_addr_q, rf_addr_d;
   logic                  rf_we_q, rf_we_d;
   logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
   logic                  pc_set_q, pc_set_d;
   logic [XLEN-1:0]       pc_set_val_q, pc_set_val_d;
   logic                  fetch_en_q, fetch_en_d;
   logic                  fatal_q, fatal_d;

   logic                  save_we_c;
   logic                  flip_c;
   logic                  drain_r_c;
   logic [XLEN-1:0]       shadow_rdata_c;

   ckpt_regfile u_ckpt_regfile (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flip_i  (flip_c),
      .we_i    (save_we_c),
      .waddr_i (rf_addr_q),
      .wdata_i (rf_rdata_i),
      .raddr_i (rf_addr_d),
      .rdata_c (shadow_rdata_c)
   );

   always_comb begin
      state_d      = state_q;
      ret_d        = ret_q;
      drn_d        = drn_q;
      retry_d      = retry_q;
      rb_d         = rb_q;
      pend_pc_d    = pend_pc_q;
      ckpt_pc_d    = ckpt_pc_q;
      rf_addr_d    = '0;
      rf_we_d      = 1'b0;
      pc_set_d     = 1'b0;
      pc_set_val_d = pc_set_val_q;
      save_we_c    = 1'b0;
      flip_c       = 1'b0;
      drain_r_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (error_i) begin
               drain_r_c = 1'b1;
            end else if (retire_i) begin
               if ((ret_q + RET_W'(1)) == RET_W'(CKPT_INTERVAL)) begin
                  ret_d   = '0;
                  drn_d   = '0;
                  state_d = ST_DRAIN_C;
               end else begin
                  ret_d = ret_q + RET_W'(1);
               end
            end
         end
         ST_DRAIN_C: begin
            if (error_i) begin
               drain_r_c = 1'b1;
            end else if (core_idle_i) begin
               pend_pc_d = pc_i;
               rf_addr_d = RF_AW'(1);
               state_d   = ST_SAVE;
            end else if (drn_q == DRN_W'(DRAIN_TIMEOUT - 1)) begin
               state_d = ST_RUN;
            end else begin
               drn_d = drn_q + DRN_W'(1);
            end
         end
         ST_SAVE: begin
            // Abort leaves the active bank untouched; the partial copy is discarded.
            if (error_i) begin
               drain_r_c = 1'b1;
            end else begin
               save_we_c = 1'b1;
               if (rf_addr_q == RF_AW'(NUM_REGS)) begin
                  flip_c    = 1'b1;
                  ckpt_pc_d = pend_pc_q;
                  retry_d   = '0;
                  state_d   = ST_RUN;
               end else begin
                  rf_addr_d = rf_addr_q + RF_AW'(1);
               end
            end
         end
         ST_DRAIN_R: begin
            if (retry_q > RETRY_W'(MAX_RETRY)) begin
               state_d = ST_FATAL;
            end else if (core_idle_i) begin
               rf_addr_d = RF_AW'(1);
               rf_we_d   = 1'b1;
               state_d   = ST_RESTORE;
            end else if (drn_q == DRN_W'(DRAIN_TIMEOUT - 1)) begin
               state_d = ST_FATAL;
            end else begin
               drn_d = drn_q + DRN_W'(1);
            end
         end
         ST_RESTORE: begin
            if (rf_addr_q == RF_AW'(NUM_REGS)) begin
               pc_set_d     = 1'b1;
               pc_set_val_d = ckpt_pc_q;
               state_d      = ST_SETPC;
            end else begin
               rf_addr_d = rf_addr_q + RF_AW'(1);
               rf_we_d   = 1'b1;
            end
         end
         ST_SETPC: begin
            ret_d   = '0;
            state_d = ST_RUN;
         end
         ST_FATAL: begin
            state_d = ST_FATAL;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Every rollback request bumps both counters on the way into DRAIN_R.
      if (drain_r_c) begin
         drn_d   = '0;
         retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
         rb_d    = (rb_q == '1) ? rb_q : rb_q + ROLLBACK_W'(1);
         state_d = ST_DRAIN_R;
      end

      rf_wdata_d = rf_we_d ? shadow_rdata_c : '0;
      fetch_en_d = (state_q == ST_RUN);
      fatal_d    = (state_d == ST_FATAL);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         ret_q        <= '0;
         drn_q        <= '0;
         retry_q      <= '0;
         rb_q         <= '0;
         pend_pc_q    <= BOOT_ADDR;
         ckpt_pc_q    <= BOOT_ADDR;
         rf_addr_q    <= '0;
         rf_we_q      <= 1'b0;
         rf_wdata_q   <= '0;
         pc_set_q     <= 1'b0;
         pc_set_val_q <= BOOT_ADDR;
         fetch_en_q   <= 1'b0;
         fatal_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ret_q        <= ret_d;
         drn_q        <= drn_d;
         retry_q      <= retry_d;
         rb_q         <= rb_d;
         pend_pc_q    <= pend_pc_d;
         ckpt_pc_q    <= ckpt_pc_d;
         rf_addr_q    <= rf_addr_d;
         rf_we_q      <= rf_we_d;
         rf_wdata_q   <= rf_wdata_d;
         pc_set_q     <= pc_set_d;
         pc_set_val_q <= pc_set_val_d;
         fetch_en_q   <= fetch_en_d;
         fatal_q      <= fatal_d;
      end
   end

   assign fetch_enable_o   = fetch_en_q;
   assign rf_addr_o        = rf_addr_q;
   assign rf_wdata_o       = rf_wdata_q;
   assign rf_we_o          = rf_we_q;
   assign pc_set_o         = pc_set_q;
   assign pc_set_val_o     = pc_set_val_q;
   assign rollback_count_o = rb_q;
   assign fatal_o          = fatal_q;
   assign state_o          = state_q;

endmodule

// File: tb/tb_lockstep_recovery_ctrl.sv
// Directed bench for lockstep_recovery_ctrl with a checkpoint-level reference model.
module tb_lockstep_recovery_ctrl;

   localparam logic [31:0] BOOT = 32'h0000_0080;
   localparam logic [2:0]  S_IDLE = 3'd0, S_RUN = 3'd1, S_DRAIN_C = 3'd2, S_SAVE = 3'd3,
                           S_DRAIN_R = 3'd4, S_RESTORE = 3'd5, S_FATAL = 3'd7;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        enable_i = 1'b0, error_i = 1'b0, retire_i = 1'b0, core_idle_i = 1'b0;
   logic [31:0] pc_i = '0;
   logic [31:0] rf_rdata_i;
   logic [31:0] rd_mul = '0;
   logic        fetch_enable_o, rf_we_o, pc_set_o, fatal_o;
   logic [4:0]  rf_addr_o;
   logic [31:0] rf_wdata_o, pc_set_val_o;
   logic [15:0] rollback_count_o;
   logic [2:0]  state_o;

   always #5 clk_i = ~clk_i;

   // Core register file stand-in: value at each index is index * rd_mul.
   always_comb rf_rdata_i = 32'(rf_addr_o) * rd_mul;

   lockstep_recovery_ctrl #(
      .CKPT_INTERVAL (4),
      .DRAIN_TIMEOUT (16),
      .MAX_RETRY     (3),
      .BOOT_ADDR     (BOOT)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .enable_i         (enable_i),
      .error_i          (error_i),
      .retire_i         (retire_i),
      .pc_i             (pc_i),
      .core_idle_i      (core_idle_i),
      .rf_rdata_i       (rf_rdata_i),
      .fetch_enable_o   (fetch_enable_o),
      .rf_addr_o        (rf_addr_o),
      .rf_wdata_o       (rf_wdata_o),
      .rf_we_o          (rf_we_o),
      .pc_set_o         (pc_set_o),
      .pc_set_val_o     (pc_set_val_o),
      .rollback_count_o (rollback_count_o),
      .fatal_o          (fatal_o),
      .state_o          (state_o)
   );

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] model_bank [32];
   logic [31:0] model_pc = BOOT;
   int          model_rb = 0;
   int          exp_addr = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Continuous check of restore traffic, redirect target and counters against the model.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         check("rollback_count", 32'(rollback_count_o), 32'(model_rb));
         if (rf_we_o) begin
            check("restore_only_in_restore", 32'(state_o), 32'(S_RESTORE));
            check("restore_addr", 32'(rf_addr_o), 32'(exp_addr));
            check("restore_data", rf_wdata_o, model_bank[rf_addr_o]);
            exp_addr++;
         end else begin
            exp_addr = 1;
         end
         if (pc_set_o) check("pc_set_val", pc_set_val_o, model_pc);
         if (fatal_o) check("fatal_fetch_off", 32'(fetch_enable_o), 32'd0);
      end
   end

   task automatic do_reset();
      rst_i = 1'b1; enable_i = 1'b0; error_i = 1'b0; retire_i = 1'b0; core_idle_i = 1'b0;
      tick();
      tick();
      model_rb = 0;
      model_pc = BOOT;
      for (int i = 0; i < 32; i++) model_bank[i] = '0;
      rst_i = 1'b0;
   endtask

   task automatic bring_up();
      enable_i = 1'b1;
      tick();
      enable_i = 1'b0;
      check("bringup_state_run", 32'(state_o), 32'(S_RUN));
      check("bringup_fetch_lag", 32'(fetch_enable_o), 32'd0);
      tick();
      check("bringup_fetch_on", 32'(fetch_enable_o), 32'd1);
   endtask

   task automatic retire_n(input int n);
      retire_i = 1'b1;
      repeat (n) tick();
      retire_i = 1'b0;
   endtask

   task automatic inject_error(input logic with_retire);
      error_i = 1'b1;
      retire_i = with_retire;
      tick();
      error_i = 1'b0;
      retire_i = 1'b0;
      model_rb++;
      check("error_to_drain_r", 32'(state_o), 32'(S_DRAIN_R));
   endtask

   // Drives a checkpoint from DRAIN_C; abort_at != 0 raises error_i at that save index.
   task automatic do_save(input int idle_wait, input logic [31:0] pc, input logic [31:0] mul,
                          input int abort_at, output int cycles);
      rd_mul = mul;
      for (int k = 0; k < idle_wait; k++) begin
         tick();
         check("drain_c_wait", 32'(state_o), 32'(S_DRAIN_C));
      end
      core_idle_i = 1'b1;
      pc_i = pc;
      tick();
      core_idle_i = 1'b0;
      cycles = 0;
      for (int k = 0; k < 40 && state_o == S_SAVE; k++) begin
         check("save_addr", 32'(rf_addr_o), 32'(k + 1));
         if (abort_at != 0 && int'(rf_addr_o) == abort_at) error_i = 1'b1;
         cycles++;
         tick();
         if (error_i) begin
            error_i = 1'b0;
            model_rb++;
         end
      end
      if (abort_at == 0 && cycles == 31 && state_o == S_RUN) begin
         for (int i = 1; i < 32; i++) model_bank[i] = 32'(i) * mul;
         model_pc = pc;
      end
   endtask

   task automatic do_restore(input int idle_wait, input int err_at,
                             output logic [31:0] last_data, output logic [31:0] pc_val);
      int nwe;
      int npc;
      nwe = 0;
      npc = 0;
      last_data = 32'hDEAD_BEEF;
      pc_val = 32'hDEAD_BEEF;
      repeat (idle_wait) tick();
      core_idle_i = 1'b1;
      tick();
      core_idle_i = 1'b0;
      for (int k = 0; k < 45 && state_o != S_RUN; k++) begin
         if (rf_we_o) nwe++;
         if (rf_we_o && rf_addr_o == 5'd31) last_data = rf_wdata_o;
         if (pc_set_o) begin
            npc++;
            pc_val = pc_set_val_o;
         end
         error_i = (k == err_at);
         tick();
      end
      error_i = 1'b0;
      check("restore_write_count", 32'(nwe), 32'd31);
      check("pc_set_pulse_count", 32'(npc), 32'd1);
      check("restore_back_to_run", 32'(state_o), 32'(S_RUN));
   endtask

   initial begin
      int          cyc;
      int          n;
      logic [31:0] last;
      logic [31:0] pcv;

      for (int i = 0; i < 32; i++) model_bank[i] = '0;

      // Reset values and bring-up.
      do_reset();
      check("rst_state", 32'(state_o), 32'(S_IDLE));
      check("rst_fetch", 32'(fetch_enable_o), 32'd0);
      check("rst_we", 32'(rf_we_o), 32'd0);
      check("rst_addr", 32'(rf_addr_o), 32'd0);
      check("rst_wdata", rf_wdata_o, 32'd0);
      check("rst_pc_set", 32'(pc_set_o), 32'd0);
      check("rst_pc_set_val", pc_set_val_o, 32'h80);
      check("rst_rollback", 32'(rollback_count_o), 32'd0);
      check("rst_fatal", 32'(fatal_o), 32'd0);
      tick();
      check("idle_hold", 32'(state_o), 32'(S_IDLE));
      bring_up();

      // Error at save index 10 before any checkpoint: restore must give zeros and BOOT_ADDR.
      retire_n(4);
      check("interval_to_drain_c", 32'(state_o), 32'(S_DRAIN_C));
      do_save(0, 32'h200, 32'd7, 10, cyc);
      check("abort_save_cycles", 32'(cyc), 32'd10);
      check("abort_to_drain_r", 32'(state_o), 32'(S_DRAIN_R));
      do_restore(2, -1, last, pcv);
      check("abort_restore_x31", last, 32'd0);
      check("abort_restore_pc", pcv, 32'h80);
      check("abort_rollback_lit", 32'(rollback_count_o), 32'd1);

      // Full checkpoint: 31 save cycles, fetch back on afterwards.
      retire_n(4);
      check("ckpt_drain_c", 32'(state_o), 32'(S_DRAIN_C));
      do_save(3, 32'h100, 32'd3, 0, cyc);
      check("save_cycles", 32'(cyc), 32'd31);
      check("save_to_run", 32'(state_o), 32'(S_RUN));
      tick();
      check("save_fetch_on", 32'(fetch_enable_o), 32'd1);

      // Rollback to that checkpoint.
      inject_error(1'b0);
      do_restore(1, -1, last, pcv);
      check("rollback_x31_lit", last, 32'd93);
      check("rollback_pc_lit", pcv, 32'h100);
      check("rollback_count_lit", 32'(rollback_count_o), 32'd2);

      // Error wins over the interval trigger; error inside RESTORE is ignored.
      retire_n(3);
      inject_error(1'b1);
      do_restore(0, -1, last, pcv);
      check("prio_restore_x31", last, 32'd93);
      inject_error(1'b0);
      do_restore(0, 5, last, pcv);
      check("restore_err_ignored_pc", pcv, 32'h100);
      check("restore_err_no_count", 32'(rollback_count_o), 32'd4);

      // Fourth error since the checkpoint exhausts the retries.
      inject_error(1'b0);
      core_idle_i = 1'b1;
      tick();
      check("retry_fatal_state", 32'(state_o), 32'(S_FATAL));
      check("retry_fatal_flag", 32'(fatal_o), 32'd1);
      check("retry_fatal_fetch", 32'(fetch_enable_o), 32'd0);
      check("retry_rollback_lit", 32'(rollback_count_o), 32'd5);
      enable_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         error_i = k[0];
         retire_i = 1'b1;
         tick();
      end
      error_i = 1'b0; retire_i = 1'b0; enable_i = 1'b0; core_idle_i = 1'b0;
      check("fatal_sticky", 32'(fatal_o), 32'd1);
      check("fatal_state_sticky", 32'(state_o), 32'(S_FATAL));
      do_reset();
      check("fatal_cleared", 32'(fatal_o), 32'd0);
      check("fatal_reset_state", 32'(state_o), 32'(S_IDLE));

      // Drain timeouts.
      bring_up();
      retire_n(4);
      n = 0;
      while (state_o == S_DRAIN_C && n < 40) begin
         n++;
         tick();
      end
      check("drain_c_timeout_cycles", 32'(n), 32'd16);
      check("drain_c_timeout_run", 32'(state_o), 32'(S_RUN));
      inject_error(1'b0);
      n = 0;
      while (state_o == S_DRAIN_R && n < 40) begin
         n++;
         tick();
      end
      check("drain_r_timeout_cycles", 32'(n), 32'd16);
      check("drain_r_timeout_fatal", 32'(state_o), 32'(S_FATAL));
      check("drain_r_timeout_flag", 32'(fatal_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lockstep_recovery_ctrl.md
Name: lockstep_recovery_ctrl

Overview:
- Checkpoint/rollback sequencer for the dual-core lockstep pair behind the fault-tolerance manager.
- Every CKPT_INTERVAL retired instructions it halts both cores, drains them, and copies core_0's register file and committed PC into a double-buffered shadow store.
- On an error pulse from the lockstep comparator it halts both cores, drains them, writes the last good checkpoint into both register files, and redirects both PCs.
- Sits between the FTM comparator and the cores' fetch-enable, register-file write and PC-set ports.

Parameters:
- CKPT_INTERVAL, 64, retired instructions between checkpoints (min 1).
- DRAIN_TIMEOUT, 16, maximum cycles to wait for core_idle_i.
- MAX_RETRY, 3, maximum consecutive rollbacks allowed with no successful checkpoint in between.
- BOOT_ADDR, 32'h0000_0080, reset checkpoint PC.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- enable_i  in  1  leave IDLE and start execution.
- error_i  in  1  lockstep mismatch pulse from FTM.
- retire_i  in  1  one instruction retired by both cores this cycle.
- pc_i  in  32  committed PC, valid when core_idle_i is high.
- core_idle_i  in  1  both pipelines drained.
- rf_rdata_i  in  32  core_0 register-file combinational read data at rf_addr_o.
- fetch_enable_o  out  1  fetch enable to both cores.
- rf_addr_o  out  5  register-file index for save/restore.
- rf_wdata_o  out  32  restore data.
- rf_we_o  out  1  restore write strobe to both register files.
- pc_set_o  out  1  one-cycle PC redirect pulse.
- pc_set_val_o  out  32  redirect target.
- rollback_count_o  out  16  saturating rollback counter.
- fatal_o  out  1  unrecoverable state, sticky until reset.
- state_o  out  3  current FSM state encoding.

Behaviour:
- Reset (rst_i sampled high at posedge), from any state:
  - State goes to IDLE. Outputs: fetch_enable_o=0, rf_we_o=0, rf_addr_o=0, rf_wdata_o=0, pc_set_o=0, pc_set_val_o=BOOT_ADDR, rollback_count_o=0, fatal_o=0.
  - Both shadow banks cleared to 0; active bank=0; checkpoint PC=BOOT_ADDR.
  - Retire counter=0; retry counter=0. A reset mid-save or mid-restore aborts it immediately.
- States: IDLE, RUN, DRAIN_C, SAVE, DRAIN_R, RESTORE, SETPC, FATAL.
- IDLE -> RUN when enable_i=1. fetch_enable_o is 1 only in RUN, registered, so it goes high the cycle after entry.
- RUN:
  - Count retire_i.
  - When the counter reaches CKPT_INTERVAL: go to DRAIN_C and clear the counter.
  - error_i=1 has priority over retire_i and over the interval trigger in the same cycle: go to DRAIN_R.
- DRAIN_C:
  - core_idle_i=1: latch pc_i into the pending PC and go to SAVE.
  - Timeout after DRAIN_TIMEOUT cycles: skip the checkpoint and return to RUN.
  - error_i=1: go to DRAIN_R.
- SAVE:
  - rf_addr_o walks 1..31, one per cycle (31 cycles). rf_rdata_i is written into the inactive bank at that index in the same cycle.
  - After index 31: flip the active bank, commit the pending PC as checkpoint PC, clear the retry counter, go to RUN.
  - error_i at any point: abort; the active bank and checkpoint PC stay unchanged; go to DRAIN_R.
- DRAIN_R:
  - core_idle_i=1: go to RESTORE.
  - Timeout: go to FATAL.
  - On entry, increment the retry counter. If it then exceeds MAX_RETRY, go to FATAL instead.
  - rollback_count_o increments (saturating at 16'hFFFF) on each DRAIN_R entry.
- RESTORE:
  - rf_addr_o walks 1..31 with rf_we_o=1 and rf_wdata_o = active bank[addr]; 31 cycles; x0 is never written.
  - error_i during RESTORE is ignored, because the cores are halted.
  - Then go to SETPC.
- SETPC: pc_set_o=1 for exactly one cycle, pc_set_val_o = checkpoint PC, retire counter cleared, then RUN.
- FATAL: fetch_enable_o=0 and fatal_o=1, held until rst_i.
- Save and restore are outputs of registered state; rf_we_o is never asserted outside RESTORE.
- Latency, error to first restore write: 1 cycle to DRAIN_R, then drain time, then 1 cycle.

Decomposition:
- Package lockstep_recovery_pkg holds:
  - the state enum (3 bits, encoding exported on state_o);
  - NUM_REGS=31;
  - the retry counter width, and the rollback counter width (16).
- Sub-module ckpt_regfile holds the two banks of 31x32 storage:
  - active-bank pointer, flip strobe, synchronous write port into the inactive bank, combinational read port from the active bank;
  - synchronous clear on rst_i.

Test Plan:
- Reset/bring-up: rst_i=1 for 2 cycles, then enable_i=1 -> state_o IDLE then RUN; fetch_enable_o=1 one cycle after RUN; all other outputs at reset values.
- Checkpoint: CKPT_INTERVAL=4, 4 retire_i pulses, core_idle_i after 3 cycles, pc_i=32'h100, rf_rdata_i=addr*3 -> exactly 31 SAVE cycles; bank flips; fetch_enable_o back to 1.
- Rollback: after that checkpoint, pulse error_i -> 31 rf_we_o writes with rf_wdata_o=addr*3 for addr 1..31; pc_set_o single pulse with 32'h100; rollback_count_o=1.
- Error mid-save: error_i at save index 10 -> the following restore writes the previous bank (zeros; PC BOOT_ADDR); checkpoint PC is not updated.
- Retry exhaustion: MAX_RETRY=3 and 4 errors with no checkpoint between -> fatal_o=1 and fetch_enable_o=0 after the 4th; held until rst_i.
- Drain timeout: core_idle_i held 0 -> DRAIN_C returns to RUN after 16 cycles with no save; DRAIN_R goes to FATAL after 16 cycles.
